// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered 6502-style ALU. Binary ops finish in one cycle;
//                decimal ADD/SUB run one BCD digit per cycle behind a
//                start/busy/valid handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_AI,
  input  logic [WIDTH-1:0] alu_BI,
  input  logic             alu_carry,
  input  logic             alu_BCD,
  output logic             alu_busy,
  output logic             alu_valid,
  output logic [WIDTH-1:0] alu_Y,
  output logic [7:0]       alu_flags
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW     = $clog2(DIGITS + 1);
  localparam int MSB    = WIDTH - 1;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_SR  = 4'b0100;
  localparam logic [3:0] OP_SL  = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_ROR = 4'b0111;
  localparam logic [3:0] OP_ROL = 4'b1000;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    BCD_RUN = 1'b1
  } state_t;

  state_t r_state, w_state_next;

  logic             w_accept, w_is_bcd, w_last;
  logic [WIDTH:0]   w_sum_add, w_sum_sub;
  logic             w_v_add, w_v_sub;
  logic [WIDTH-1:0] w_bin_y;
  logic             w_bin_c, w_bin_v, w_bin_def;
  logic [7:0]       w_bin_flags;

  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_res;
  logic             r_dcarry, r_sub, r_v;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       w_dig;
  logic             w_dig_c;
  logic [WIDTH+3:0] w_res_cat;
  logic [WIDTH-1:0] w_res_next;

  assign w_accept = alu_start && (r_state == IDLE);
  assign w_is_bcd = alu_BCD && ((alu_ctrl == OP_ADD) || (alu_ctrl == OP_SUB));
  assign w_last   = (r_cnt == CW'(DIGITS - 1));

  // Full-width sums shared by binary ADD/SUB and the decimal-mode V flag
  assign w_sum_add = {1'b0, alu_AI} + {1'b0, alu_BI}  + {{WIDTH{1'b0}}, alu_carry};
  assign w_sum_sub = {1'b0, alu_AI} + {1'b0, ~alu_BI} + {{WIDTH{1'b0}}, alu_carry};
  assign w_v_add   = (alu_AI[MSB] == alu_BI[MSB]) && (w_sum_add[MSB] != alu_AI[MSB]);
  assign w_v_sub   = (alu_AI[MSB] != alu_BI[MSB]) && (w_sum_sub[MSB] != alu_AI[MSB]);

  // Single-cycle binary result and carry/overflow selection
  always_comb begin
    w_bin_y   = '0;
    w_bin_c   = 1'b0;
    w_bin_v   = 1'b0;
    w_bin_def = 1'b1;
    case (alu_ctrl)
      OP_ADD: begin w_bin_y = w_sum_add[WIDTH-1:0]; w_bin_c = w_sum_add[WIDTH]; w_bin_v = w_v_add; end
      OP_SUB: begin w_bin_y = w_sum_sub[WIDTH-1:0]; w_bin_c = w_sum_sub[WIDTH]; w_bin_v = w_v_sub; end
      OP_OR:  w_bin_y = alu_AI | alu_BI;
      OP_XOR: w_bin_y = alu_AI ^ alu_BI;
      OP_AND: w_bin_y = alu_AI & alu_BI;
      OP_SR:  begin w_bin_y = {1'b0, alu_AI[MSB:1]};      w_bin_c = alu_AI[0];   end
      OP_SL:  begin w_bin_y = {alu_AI[MSB-1:0], 1'b0};    w_bin_c = alu_AI[MSB]; end
      OP_ROR: begin w_bin_y = {alu_carry, alu_AI[MSB:1]}; w_bin_c = alu_AI[0];   end
      OP_ROL: begin w_bin_y = {alu_AI[MSB-1:0], alu_carry}; w_bin_c = alu_AI[MSB]; end
      default: w_bin_def = 1'b0;
    endcase
    // Undefined opcodes report all-zero flags, including Z
    w_bin_flags = w_bin_def ? {w_bin_y[MSB], w_bin_v, 4'b0000, (w_bin_y == '0), w_bin_c} : 8'h00;
  end

  // One decimal digit step on the low nibble of the shifting operands
  always_comb begin
    logic [4:0] s;
    logic [5:0] d;
    s       = {1'b0, r_a_sh[3:0]} + {1'b0, r_b_sh[3:0]} + {4'b0000, r_dcarry};
    d       = {2'b00, r_a_sh[3:0]} - {2'b00, r_b_sh[3:0]} - {5'b00000, ~r_dcarry};
    w_dig   = 4'h0;
    w_dig_c = 1'b0;
    if (r_sub) begin
      if (d[5]) begin
        d       = d - 6'd6;
        w_dig_c = 1'b0;
      end else begin
        w_dig_c = 1'b1;
      end
      w_dig = d[3:0];
    end else begin
      if (s > 5'd9) begin
        s       = s + 5'd6;
        w_dig_c = 1'b1;
      end else begin
        w_dig_c = 1'b0;
      end
      w_dig = s[3:0];
    end
  end

  // New digit enters at the top; after DIGITS steps it sits in the LSB nibble
  assign w_res_cat  = {w_dig, r_res};
  assign w_res_next = w_res_cat[WIDTH+3:4];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic and busy output
  always_comb begin
    w_state_next = r_state;
    alu_busy     = (r_state == BCD_RUN);
    case (r_state)
      IDLE:    if (w_accept && w_is_bcd) w_state_next = BCD_RUN;
      BCD_RUN: if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand latching, digit iteration and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_Y     <= '0;
      alu_flags <= 8'h00;
      alu_valid <= 1'b0;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_res     <= '0;
      r_dcarry  <= 1'b0;
      r_sub     <= 1'b0;
      r_v       <= 1'b0;
      r_cnt     <= '0;
    end else begin
      alu_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (w_accept) begin
          if (w_is_bcd) begin
            r_a_sh   <= alu_AI;
            r_b_sh   <= alu_BI;
            r_res    <= '0;
            r_dcarry <= alu_carry;
            r_sub    <= (alu_ctrl == OP_SUB);
            r_v      <= (alu_ctrl == OP_SUB) ? w_v_sub : w_v_add;
            r_cnt    <= '0;
          end else begin
            alu_Y     <= w_bin_y;
            alu_flags <= w_bin_flags;
            alu_valid <= 1'b1;
          end
        end
      end else begin
        r_a_sh   <= r_a_sh >> 4;
        r_b_sh   <= r_b_sh >> 4;
        r_res    <= w_res_next;
        r_dcarry <= w_dig_c;
        r_cnt    <= r_cnt + CW'(1);
        if (w_last) begin
          alu_Y     <= w_res_next;
          alu_flags <= {w_res_next[MSB], r_v, 4'b0000, (w_res_next == '0), w_dig_c};
          alu_valid <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed self-checking bench for alu_seq at WIDTH 8 and 16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam logic [3:0] ADD = 4'h0, OR_ = 4'h1, XOR_ = 4'h2, AND_ = 4'h3;
  localparam logic [3:0] SR = 4'h4, SL = 4'h5, SUB = 4'h6, ROR = 4'h7, ROL = 4'h8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ctrl = 4'h0;
  logic [15:0] a = 16'h0, b = 16'h0;
  logic        cin = 1'b0, bcd = 1'b0;
  logic        start8 = 1'b0, start16 = 1'b0;

  logic        busy8, valid8, busy16, valid16;
  logic [7:0]  y8, flags8, flags16;
  logic [15:0] y16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .alu_start(start8), .alu_ctrl(ctrl),
    .alu_AI(a[7:0]), .alu_BI(b[7:0]), .alu_carry(cin), .alu_BCD(bcd),
    .alu_busy(busy8), .alu_valid(valid8), .alu_Y(y8), .alu_flags(flags8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .alu_start(start16), .alu_ctrl(ctrl),
    .alu_AI(a), .alu_BI(b), .alu_carry(cin), .alu_BCD(bcd),
    .alu_busy(busy16), .alu_valid(valid16), .alu_Y(y16), .alu_flags(flags16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic bm);
    ctrl = c; a = av; b = bv; cin = ci; bcd = bm;
  endtask

  // Issue one op and wait (bounded) for its valid pulse
  task automatic run(input string tag, input bit w16, input logic [3:0] c,
                     input logic [15:0] av, input logic [15:0] bv, input logic ci,
                     input logic bm, input int exp_lat, input logic [15:0] exp_y,
                     input logic [7:0] exp_fl);
    int lat;
    bit got, saw_busy;
    logic [15:0] yo;
    logic [7:0]  fo;
    got = 0; saw_busy = 0; lat = 0; yo = '0; fo = '0;
    @(negedge clk);
    drive(c, av, bv, ci, bm);
    if (w16) start16 = 1'b1; else start8 = 1'b1;
    for (int i = 1; i <= 12 && !got; i++) begin
      @(negedge clk);
      start8 = 1'b0; start16 = 1'b0;
      lat = i;
      if ((w16 ? busy16 : busy8) === 1'b1) saw_busy = 1;
      if ((w16 ? valid16 : valid8) === 1'b1) begin
        got = 1;
        yo  = w16 ? y16 : {8'h00, y8};
        fo  = w16 ? flags16 : flags8;
      end
    end
    check({tag, " valid seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " Y"}, yo, exp_y);
    check({tag, " flags"}, fo, exp_fl);
    if (exp_lat == 1) check({tag, " busy"}, 32'(saw_busy), 32'd0);
  endtask

  initial begin
    bit seen;
    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", busy8, 1'b0);
    check("reset valid", valid8, 1'b0);
    check("reset Y", y8, 8'h00);
    check("reset flags", flags8, 8'h00);
    rst = 1'b0;

    // Binary ops, 8 bits
    run("add 50+50", 0, ADD, 16'h50, 16'h50, 0, 0, 1, 16'h00A0, 8'hC0);
    run("sub 50-b0", 0, SUB, 16'h50, 16'hB0, 1, 0, 1, 16'h00A0, 8'hC0);
    run("or", 0, OR_, 16'h0F, 16'hF0, 0, 0, 1, 16'h00FF, 8'h80);
    run("xor", 0, XOR_, 16'hAA, 16'hAA, 1, 0, 1, 16'h0000, 8'h02);
    run("sl 81", 0, SL, 16'h81, 16'h00, 0, 0, 1, 16'h0002, 8'h01);

    // BCD ADD with ignored mid-op start, then back-to-back BCD SUB
    @(negedge clk);
    drive(ADD, 16'h58, 16'h46, 1, 1); start8 = 1'b1;
    @(negedge clk);
    check("bcd add busy c1", busy8, 1'b1);
    check("bcd add valid c1", valid8, 1'b0);
    a = 16'h11;
    @(negedge clk);
    start8 = 1'b0;
    check("bcd add busy c2", busy8, 1'b1);
    @(negedge clk);
    check("bcd add valid c3", valid8, 1'b1);
    check("bcd add busy c3", busy8, 1'b0);
    check("bcd add Y", y8, 8'h05);
    check("bcd add flags", flags8, 8'h41);
    drive(SUB, 16'h32, 16'h15, 1, 1); start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("b2b valid gap", valid8, 1'b0);
    check("b2b busy", busy8, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("bcd sub valid", valid8, 1'b1);
    check("bcd sub Y", y8, 8'h17);
    check("bcd sub flags", flags8, 8'h01);
    run("bcd sub neg", 0, SUB, 16'h15, 16'h32, 1, 1, 3, 16'h0083, 8'h80);

    // Shifts, rotates, undefined opcode
    run("rol 80", 0, ROL, 16'h80, 16'h00, 1, 0, 1, 16'h0001, 8'h01);
    run("sr 01", 0, SR, 16'h01, 16'h00, 0, 0, 1, 16'h0000, 8'h03);
    run("undef op", 0, 4'hF, 16'h37, 16'h21, 1, 0, 1, 16'h0000, 8'h00);
    run("ror 02", 0, ROR, 16'h02, 16'h00, 1, 0, 1, 16'h0081, 8'h80);

    // Reset in the middle of a BCD op
    @(negedge clk);
    drive(ADD, 16'h58, 16'h46, 1, 1); start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", busy8, 1'b0);
    check("midrst valid", valid8, 1'b0);
    check("midrst Y", y8, 8'h00);
    check("midrst flags", flags8, 8'h00);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid8 !== 1'b0) seen = 1;
    end
    check("midrst no valid", 32'(seen), 32'd0);
    run("and f0&0f", 0, AND_, 16'hF0, 16'h0F, 0, 0, 1, 16'h0000, 8'h02);

    // 16-bit instance
    run("w16 bcd 9999+1", 1, ADD, 16'h9999, 16'h0001, 0, 1, 5, 16'h0000, 8'h03);
    run("w16 add ffff+1", 1, ADD, 16'hFFFF, 16'h0001, 0, 0, 1, 16'h0000, 8'h03);
    run("w16 bcd 1000-1", 1, SUB, 16'h1000, 16'h0001, 1, 1, 5, 16'h0999, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Registered, parametrised-width ALU for the 6502 datapath. It generalises the combinational ALU in two ways: it adds SUB and the rotates, and it adds true decimal (BCD) ADD/SUB. Binary ops complete in one cycle. BCD ops run nibble-serially over WIDTH/4 cycles behind a start/busy/valid handshake. The control unit issues one op at a time and samples the result and flags on alu_valid.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of 4, minimum 4.
DIGITS, WIDTH/4, BCD digit count (derived localparam, not overridable).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
alu_start  input  1  op request; accepted when high and alu_busy low.
alu_ctrl  input  4  opcode, sampled on accept.
alu_AI  input  WIDTH  operand A, sampled on accept.
alu_BI  input  WIDTH  operand B, sampled on accept.
alu_carry  input  1  carry in (SBC convention: 1 = no borrow), sampled on accept.
alu_BCD  input  1  decimal mode, sampled on accept; affects ADD/SUB only.
alu_busy  output  1  op in progress; new starts ignored.
alu_valid  output  1  one-cycle pulse; alu_Y/alu_flags are new this cycle.
alu_Y  output  WIDTH  registered result, held until next completion.
alu_flags  output  8  registered flags in 6502 P positions: bit0 C, bit1 Z, bit6 V, bit7 N; other bits always 0.

Behaviour:
- Opcodes: ADD=0000, OR=0001, XOR=0010, AND=0011, SR=0100, SL=0101, SUB=0110, ROR=0111, ROL=1000. Other codes complete as binary ops with Y=0, flags=0.
- Reset (rst high at clock edge): state IDLE; alu_busy=0, alu_valid=0, alu_Y=0, alu_flags=0. Reset takes priority over everything, including mid-BCD operation; the partial result is discarded and no valid pulse is produced.
- States: IDLE, BCD_RUN.
- IDLE with accepted start, binary op (not ADD/SUB with BCD=1): result and flags are registered on the same edge. alu_valid is high the next cycle. Latency is 1 and alu_busy stays 0.
- IDLE with accepted start, BCD ADD/SUB: operands are latched and the state goes to BCD_RUN with digit index 0. alu_busy=1.
- BCD_RUN: each edge processes digit k (LSB first) and propagates the decimal carry. On the DIGITS-th edge, Y/flags are written, alu_valid pulses, and the state returns to IDLE. Latency is DIGITS+1 cycles from the accept edge to the valid cycle.
- alu_busy drops in the valid cycle, so a start in that cycle is accepted (back-to-back).
- alu_start while busy is ignored, not queued. Inputs are don't-care while busy.
- alu_valid is never high in two consecutive cycles for BCD ops. It may be high in consecutive cycles for back-to-back binary ops.
- ADD binary: R = A + B + Cin, full WIDTH+1 bit sum. C is the carry out. V = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
- SUB binary: R = A + ~B + Cin. C = 1 when there is no borrow. V = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
- BCD ADD digit: s = a + b + c. If s > 9, then s += 6 and c = 1; else c = 0. The digit is s[3:0].
- BCD SUB digit: d = a - b - ~c. If d < 0, then d -= 6 and c = 0; else c = 1. The digit is d[3:0].
- BCD flags: C is the final decimal carry. Z and N come from the decimal result. V is computed from the equivalent binary ADD/SUB of the latched operands. Non-BCD digits (A-F) produce defined but unspecified results.
- Logic ops (OR/XOR/AND): C=0, V=0.
- SR: Y = {0, A[msb:1]}, C = A[0].
- SL: Y = {A[msb-1:0], 0}, C = A[msb].
- ROR: Y = {Cin, A[msb:1]}, C = A[0].
- ROL: Y = {A[msb-1:0], Cin}, C = A[msb].
- Shifts/rotates use A only and set V=0.
- All ops: Z = (Y==0), N = Y[msb].

Test Plan:
1. Binary ADD, W=8: A=0x50, B=0x50, Cin=0 -> Y=0xA0, flags N=1 V=1 Z=0 C=0, valid exactly 1 cycle after accept, busy never asserted.
2. BCD ADD, W=8: A=0x58, B=0x46, Cin=1 -> Y=0x05, C=1, Z=0, N=0. Busy for 2 cycles, valid on 3rd cycle after accept. A start pulsed mid-op with A=0x11 is ignored. A start in the valid cycle is accepted.
3. BCD SUB, W=8: 0x32-0x15 with Cin=1 -> Y=0x17, C=1. Then 0x15-0x32 with Cin=1 -> Y=0x83, C=0, N=1.
4. Shifts/rotates: ROL A=0x80, Cin=1 -> Y=0x01, C=1. SR A=0x01 -> Y=0x00, Z=1, C=1. ROR A=0x02, Cin=1 -> Y=0x81, N=1, C=0. Undefined opcode 0xF -> Y=0, flags=0.
5. Reset mid-op: BCD ADD accepted, rst asserted on the next edge -> busy=0, Y=0, flags=0 the following cycle, no valid pulse. A subsequent binary AND 0xF0&0x0F -> Y=0, Z=1.
6. W=16: BCD ADD 0x9999+0x0001, Cin=0 -> Y=0x0000, C=1, Z=1, valid 5 cycles after accept. Binary ADD 0xFFFF+0x0001 -> Y=0x0000, C=1, Z=1, V=0.
